lfsr_rand_gen: RTL and testbench

Parametrised pseudo-random source for the game logic. It runs a free-running Fibonacci LFSR of configurable width and taps, with a runtime-loadable seed. On request it delivers a uniformly distributed value in [0, RANGE) through a req/valid handshake, for example the next mole hole. Latency is bounded by rejection sampling with a fallback.

---
 rtl/lfsr_rand_pkg.sv | 27 ++
 rtl/lfsr_rand_gen_if.sv | 24 ++
 rtl/lfsr_core.sv | 32 +++
 rtl/lfsr_rand_gen.sv | 143 ++++++++++++++
 tb/tb_lfsr_rand_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_rand_pkg.sv
// Shared types and constants for the LFSR random source.
// Holds the draw FSM state enum, reference tap masks and seeds for common
// widths, and the RANGE/OUT_W legality check used at elaboration.
package lfsr_rand_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Maximal-length Fibonacci polynomials and nonzero default seeds
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [7:0]  SEED_W8  = 8'h55;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [15:0] SEED_W16 = 16'h5555;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
    localparam logic [31:0] SEED_W32 = 32'h5555_5555;

    // A candidate of out_w bits must cover the range but waste at most half
    // of its codes, otherwise rejection sampling needs too many tries.
    function automatic bit range_ok(input int range, input int out_w);
        longint span;
        span = longint'(1) << out_w;
        return (range >= 2) && (span >= longint'(range)) && (span <= 2 * longint'(range));
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Seed/request/result bundle of the LFSR random source.
// master: game logic side; slave: the generator.
interface lfsr_rand_gen_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4
);
    logic             I_seed_load;
    logic [WIDTH-1:0] I_seed;
    logic             I_req;
    logic             O_valid;
    logic [OUT_W-1:0] O_value;
    logic             O_busy;
    logic [WIDTH-1:0] O_pseudo_random;

    modport master (
        output I_seed_load, I_seed, I_req,
        input  O_valid, O_value, O_busy, O_pseudo_random
    );

    modport slave (
        input  I_seed_load, I_seed, I_req,
        output O_valid, O_value, O_busy, O_pseudo_random
    );
endinterface

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with a loadable seed.
// A zero seed is replaced by DEFAULT_SEED so the lock-up state never occurs.
module lfsr_core
    import lfsr_rand_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_W16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_W16
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_load,
    input  logic [WIDTH-1:0] I_seed,
    output logic [WIDTH-1:0] O_state
);

    logic feedback;

    assign feedback = ^(O_state & TAPS);

    // Load wins over stepping; otherwise shift left and insert the parity of the taps
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_state <= DEFAULT_SEED;
        end else if (I_load) begin
            O_state <= (I_seed == '0) ? DEFAULT_SEED : I_seed;
        end else begin
            O_state <= {O_state[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Bounded pseudo-random value source: LFSR plus rejection-sampling FSM.
// A request draws the low OUT_W bits of the LFSR until one lands in
// [0, RANGE); after MAX_TRIES rejects the last candidate is folded into range.
// Optional macro LFSR_NO_REPEAT_EN: never deliver the same value twice in a row.
module lfsr_rand_gen
    import lfsr_rand_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_W16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_W16,
    parameter int               OUT_W        = 4,
    parameter int               RANGE        = 9,
    parameter int               MAX_TRIES    = 8
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    lfsr_rand_gen_if.slave bus
);

    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);

    if (!range_ok(RANGE, OUT_W) || WIDTH < 3 || MAX_TRIES < 1 || OUT_W > WIDTH) begin : g_bad_cfg
        $error("lfsr_rand_gen: illegal WIDTH/OUT_W/RANGE/MAX_TRIES combination");
    end

    logic [WIDTH-1:0] lfsr_q;
    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             valid_q;
    logic [OUT_W-1:0] value_q, value_d;
    logic             deliver;
    logic [OUT_W-1:0] cand;
    logic [OUT_W:0]   cand_x;
    logic             in_range;
    logic             accept;
    logic             last_try;
    logic [OUT_W-1:0] wrapped;
    logic [OUT_W-1:0] fallback;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_load  (bus.I_seed_load),
        .I_seed  (bus.I_seed),
        .O_state (lfsr_q)
    );

    assign cand     = lfsr_q[OUT_W-1:0];
    assign cand_x   = {1'b0, cand};
    assign in_range = cand_x < RANGE_X;
    assign wrapped  = in_range ? cand : OUT_W'(cand_x - RANGE_X);
    assign last_try = (tries_q == LAST_TRY);

`ifdef LFSR_NO_REPEAT_EN
    logic [OUT_W-1:0] last_q;
    logic             last_ok_q;
    logic             is_repeat;
    logic             fb_repeat;
    logic [OUT_W:0]   bumped;

    assign is_repeat = last_ok_q && (cand == last_q);
    assign accept    = in_range && !is_repeat;
    assign fb_repeat = last_ok_q && (wrapped == last_q);
    assign bumped    = {1'b0, wrapped} + (OUT_W + 1)'(1);
    assign fallback  = !fb_repeat          ? wrapped :
                       (bumped == RANGE_X) ? '0      : bumped[OUT_W-1:0];

    // Remember every delivered value so the next draw can avoid it
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            last_q    <= '0;
            last_ok_q <= 1'b0;
        end else if (deliver) begin
            last_q    <= value_d;
            last_ok_q <= 1'b1;
        end
    end
`else
    assign accept   = in_range;
    assign fallback = wrapped;
`endif

    // FSM state, try counter and registered result
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
            tries_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            valid_q <= deliver;
            value_q <= value_d;
        end
    end

    // Leave IDLE on a request, return once a value has been delivered
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.I_req) state_d = DRAW;
            DRAW:    if (deliver)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accept, fall back on the final try, or count another reject
    always_comb begin
        deliver = 1'b0;
        value_d = value_q;
        tries_d = tries_q;
        case (state_q)
            IDLE: begin
                if (bus.I_req) tries_d = '0;
            end
            DRAW: begin
                if (accept) begin
                    deliver = 1'b1;
                    value_d = cand;
                end else if (last_try) begin
                    deliver = 1'b1;
                    value_d = fallback;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.O_valid         = valid_q;
    assign bus.O_value         = value_q;
    assign bus.O_busy          = (state_q == DRAW);
    assign bus.O_pseudo_random = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Testbench for lfsr_rand_gen: table of seeded draws, hand-written corner
// sequences, and random requests against a transaction-level reference.
// Build with +define+LFSR_NO_REPEAT_EN to exercise the no-repeat variant.
module tb_lfsr_rand_gen;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED  = 16'h5555;
    localparam int          RANGE = 9;
    localparam int          NREQ  = 1000;

    typedef struct {
        string       name;
        logic [15:0] seed;
        int          exp_value;
        int          exp_lat;
        bit          pulse;
    } vec_t;

    logic I_clk   = 1'b0;
    logic I_rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl_lfsr;
    logic [3:0]  mdl_last;
    bit          mdl_last_ok;

    lfsr_rand_gen_if #(.WIDTH(16), .OUT_W(4)) bus  ();
    lfsr_rand_gen_if #(.WIDTH(16), .OUT_W(4)) bus1 ();

    lfsr_rand_gen dut (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .bus     (bus)
    );

    lfsr_rand_gen #(.MAX_TRIES(1)) dut1 (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .bus     (bus1)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Next LFSR state: double the value, add the tap parity, keep 16 bits
    function automatic logic [15:0] refNext(input logic [15:0] s);
        int ones;
        ones = $countones(s & TAPS);
        return 16'((32'(s) * 2 + ones % 2) % 65536);
    endfunction

    // Whole-request outcome from the LFSR value seen at the first DRAW edge
    function automatic void refDraw(input logic [15:0] s0, input int max_tries,
                                    input bit use_last, input int last,
                                    output int value, output int lat);
        logic [15:0] s;
        int cand;
        s     = s0;
        value = -1;
        lat   = 0;
        for (int t = 0; t < max_tries; t++) begin
            cand = int'(s % 16);
            if (cand < RANGE && !(use_last && cand == last)) begin
                value = cand;
                lat   = t + 1;
                return;
            end
            if (t == max_tries - 1) begin
                value = cand % RANGE;
                if (use_last && value == last) value = (value + 1) % RANGE;
                lat = t + 1;
                return;
            end
            s = refNext(s);
        end
    endfunction

    function automatic bit useLast();
`ifdef LFSR_NO_REPEAT_EN
        return mdl_last_ok;
`else
        return 1'b0;
`endif
    endfunction

    task automatic applyStimulus(input bit req, input bit load, input logic [15:0] seed);
        bus.I_req       = req;
        bus.I_seed_load = load;
        bus.I_seed      = seed;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, then land on the falling edge to sample
    task automatic stepCycle();
        @(posedge I_clk);
        if (!I_rst_n)             mdl_lfsr = SEED;
        else if (bus.I_seed_load) mdl_lfsr = (bus.I_seed == 16'h0) ? SEED : bus.I_seed;
        else                      mdl_lfsr = refNext(mdl_lfsr);
        @(negedge I_clk);
    endtask

    task automatic runDraw(input string name, input bit load, input logic [15:0] seed,
                           input int exp_value, input int exp_lat, input bit pulse);
        applyStimulus(1'b1, load, seed);
        stepCycle();
        checkOutput({name, " busy-start"}, 32'(bus.O_busy), 1);
        for (int i = 1; i < exp_lat; i++) begin
            applyStimulus(pulse, 1'b0, 16'h0);
            stepCycle();
            checkOutput({name, " early-valid"}, 32'(bus.O_valid), 0);
            checkOutput({name, " busy-mid"}, 32'(bus.O_busy), 1);
        end
        applyStimulus(pulse, 1'b0, 16'h0);
        stepCycle();
        checkOutput({name, " valid"}, 32'(bus.O_valid), 1);
        checkOutput({name, " value"}, 32'(bus.O_value), 32'(exp_value));
        checkOutput({name, " busy-end"}, 32'(bus.O_busy), 0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        mdl_last    = 4'(exp_value);
        mdl_last_ok = 1'b1;
    endtask

    initial begin
        vec_t vecs[6];
        logic [15:0] sd;
        int exp_v, exp_l, prev;
        bit ld;

        vecs[0] = '{"seed3",   16'h0003, 3, 1, 1'b0};
        vecs[1] = '{"seedF",   16'h000F, 8, 4, 1'b1};
        vecs[2] = '{"seed0",   16'h0000, 5, 1, 1'b0};
        vecs[3] = '{"seed10",  16'h0010, 0, 1, 1'b1};
        vecs[4] = '{"seed9",   16'h0009, 2, 2, 1'b0};
        vecs[5] = '{"seedFF",  16'h00FF, 8, 4, 1'b1};

        mdl_lfsr    = SEED;
        mdl_last    = 4'h0;
        mdl_last_ok = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0);
        bus1.I_req       = 1'b0;
        bus1.I_seed_load = 1'b0;
        bus1.I_seed      = 16'h0;

        // Reset values
        @(negedge I_clk);
        stepCycle();
        checkOutput("rst valid", 32'(bus.O_valid), 0);
        checkOutput("rst value", 32'(bus.O_value), 0);
        checkOutput("rst busy", 32'(bus.O_busy), 0);
        checkOutput("rst lfsr", 32'(bus.O_pseudo_random), 32'h5555);

        // Free run from the default seed
        I_rst_n = 1'b1;
        stepCycle();
        checkOutput("run1 lfsr", 32'(bus.O_pseudo_random), 32'hAAAA);
        stepCycle();
        checkOutput("run2 lfsr", 32'(bus.O_pseudo_random), 32'h5554);
        checkOutput("run2 idle busy", 32'(bus.O_busy), 0);

        // Zero seed is substituted
        applyStimulus(1'b0, 1'b1, 16'h0000);
        stepCycle();
        checkOutput("zero seed lfsr", 32'(bus.O_pseudo_random), 32'h5555);
        applyStimulus(1'b0, 1'b0, 16'h0);

        // Seeded draws from the table; each result must last one cycle and be held
        for (int v = 0; v < 6; v++) begin
            runDraw(vecs[v].name, 1'b1, vecs[v].seed, vecs[v].exp_value, vecs[v].exp_lat, vecs[v].pulse);
            for (int j = 0; j < 3; j++) begin
                stepCycle();
                checkOutput({vecs[v].name, " no extra valid"}, 32'(bus.O_valid), 0);
                checkOutput({vecs[v].name, " value held"}, 32'(bus.O_value), 32'(vecs[v].exp_value));
            end
            checkOutput({vecs[v].name, " lfsr track"}, 32'(bus.O_pseudo_random), 32'(mdl_lfsr));
        end

        // Single try: candidate 15 folds to 6
        bus1.I_req       = 1'b1;
        bus1.I_seed_load = 1'b1;
        bus1.I_seed      = 16'h000F;
        stepCycle();
        bus1.I_req       = 1'b0;
        bus1.I_seed_load = 1'b0;
        checkOutput("mt1 busy", 32'(bus1.O_busy), 1);
        stepCycle();
        checkOutput("mt1 valid", 32'(bus1.O_valid), 1);
        checkOutput("mt1 value", 32'(bus1.O_value), 6);
        stepCycle();
        checkOutput("mt1 pulse end", 32'(bus1.O_valid), 0);

`ifdef LFSR_NO_REPEAT_EN
        // Same seed twice: the repeat 3 is rejected and 6 follows a cycle later
        runDraw("nr first", 1'b1, 16'h0003, 3, 1, 1'b0);
        stepCycle();
        runDraw("nr repeat", 1'b1, 16'h0003, 6, 2, 1'b0);
        stepCycle();
`endif

        // Asynchronous reset in the middle of a draw
        applyStimulus(1'b1, 1'b1, 16'h000F);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'h0);
        stepCycle();
        #2 I_rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus.O_busy), 0);
        checkOutput("abort valid", 32'(bus.O_valid), 0);
        checkOutput("abort value", 32'(bus.O_value), 0);
        checkOutput("abort lfsr", 32'(bus.O_pseudo_random), 32'h5555);
        stepCycle();
        I_rst_n     = 1'b1;
        mdl_last_ok = 1'b0;
        for (int j = 0; j < 6; j++) begin
            stepCycle();
            checkOutput("abort no valid", 32'(bus.O_valid), 0);
            checkOutput("abort lfsr track", 32'(bus.O_pseudo_random), 32'(mdl_lfsr));
        end

        // Random requests, idle gaps and seed loads against the reference
        prev = -1;
        for (int r = 0; r < NREQ; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                sd = 16'($urandom);
                if ($urandom_range(0, 7) == 0) sd = 16'h0;
                applyStimulus(1'b0, $urandom_range(0, 3) == 0, sd);
                stepCycle();
                checkOutput("rnd idle lfsr", 32'(bus.O_pseudo_random), 32'(mdl_lfsr));
                checkOutput("rnd idle valid", 32'(bus.O_valid), 0);
            end
            sd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) sd = 16'h0;
            ld = ($urandom_range(0, 3) == 0);
            applyStimulus(1'b1, ld, sd);
            stepCycle();
            refDraw(mdl_lfsr, 8, useLast(), int'(mdl_last), exp_v, exp_l);
            checkOutput("rnd start busy", 32'(bus.O_busy), 1);
            for (int i = 1; i < exp_l; i++) begin
                applyStimulus($urandom_range(0, 1) == 1, 1'b0, 16'h0);
                stepCycle();
                checkOutput("rnd early valid", 32'(bus.O_valid), 0);
            end
            applyStimulus($urandom_range(0, 1) == 1, 1'b0, 16'h0);
            stepCycle();
            checkOutput("rnd valid", 32'(bus.O_valid), 1);
            checkOutput("rnd value", 32'(bus.O_value), 32'(exp_v));
            checkOutput("rnd lfsr", 32'(bus.O_pseudo_random), 32'(mdl_lfsr));
`ifdef LFSR_NO_REPEAT_EN
            checkOutput("rnd bound", 32'(int'(bus.O_value) < RANGE), 1);
            checkOutput("rnd no repeat", 32'(int'(bus.O_value) != prev), 1);
`endif
            prev        = int'(bus.O_value);
            mdl_last    = 4'(exp_v);
            mdl_last_ok = 1'b1;
            applyStimulus(1'b0, 1'b0, 16'h0);
        end

        stepCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
